// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Generic pipeline stage register with a valid/ready handshake and a two-entry skid
//   buffer. The payload is a single packed vector, so every stage (IF/ID, ID/EX, EX/MEM,
//   MEM/WB) uses the same module with its own struct width. in_ready comes straight from a
//   flop, so there is no combinational path from out_ready back to in_ready.
//
// Parameters
//   DATA_W    payload width in bits (>= 1)
//   CNT_W     stall counter width (only used when PIPE_STAGE_PERF_EN is defined)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush; all held entries become bubbles
//   in_valid   upstream presents in_data
//   in_ready   stage can accept (registered, = !skid_valid)
//   in_data    upstream payload
//   out_valid  out_data is valid
//   out_ready  downstream accepts this cycle
//   out_data   payload from the main register ('0 whenever out_valid = 0)
//   stall_cnt  saturating count of out_valid & !out_ready cycles (PIPE_STAGE_PERF_EN only)
//
// Build option
//   PIPE_STAGE_PERF_EN  adds the stall_cnt port and its counter.

module pipe_stage_skid_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   // Occupancy encoded as {skid_valid, main_valid}; 2'b10 cannot be reached.
   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StOne   = 2'b01,
      StTwo   = 2'b11
   } state_e;

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;

   logic   accept;
   logic   drain;
   state_e state;

   assign state     = state_e'({skid_valid_q, main_valid_q});
   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

   assign accept = in_valid & in_ready;
   assign drain  = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;

      if (flush) begin
         // Flush beats accept and drain: anything taken this cycle is dropped.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_data_d  = '0;
         skid_data_d  = '0;
      end else begin
         case (state)
            StEmpty: begin
               if (accept) begin
                  main_valid_d = 1'b1;
                  main_data_d  = in_data;
               end
            end
            StOne: begin
               if (accept && drain) begin
                  main_data_d = in_data;
               end else if (accept) begin
                  skid_valid_d = 1'b1;
                  skid_data_d  = in_data;
               end else if (drain) begin
                  // Clear the payload so an empty stage always shows a clean bubble.
                  main_valid_d = 1'b0;
                  main_data_d  = '0;
               end
            end
            StTwo: begin
               if (drain) begin
                  main_data_d  = skid_data_q;
                  skid_valid_d = 1'b0;
                  skid_data_d  = '0;
               end
            end
            default: begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
               main_data_d  = '0;
               skid_data_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;

   // Saturating; flush deliberately leaves it alone so stalls survive pipeline redirects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (main_valid_q && !out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule
